// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: EX/ID hazard inputs and hold/redirect outputs.
// master drives requests and consumes holds; slave is pipe_ctrl.
interface pipe_ctrl_if;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_ex_i;
  logic        hold_flag_clint_i;
  logic        hold_flag_rib_i;
  logic        ld_ex_i;
  logic [4:0]  ex_rd_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic [2:0]  hold_flag_o;
  logic        bubble_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [1:0]  state_o;

  modport master (
    output jump_flag_i, jump_addr_i,
    output hold_flag_ex_i, hold_flag_clint_i,
    output hold_flag_rib_i, ld_ex_i,
    output ex_rd_i, id_rs1_i, id_rs2_i,
    input  hold_flag_o, bubble_o,
    input  jump_flag_o, jump_addr_o, state_o
  );

  modport slave (
    input  jump_flag_i, jump_addr_i,
    input  hold_flag_ex_i, hold_flag_clint_i,
    input  hold_flag_rib_i, ld_ex_i,
    input  ex_rd_i, id_rs1_i, id_rs2_i,
    output hold_flag_o, bubble_o,
    output jump_flag_o, jump_addr_o, state_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush/load-use controller (IDLE/FLUSH/LDSTALL FSM).
// Ports: clk, rst (sync, active-low), bus (pipe_ctrl_if.slave);
// PIPE_CTRL_STAT_EN adds stall_cnt_o / flush_cnt_o saturating counters.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_STAT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    LDSTALL = 2'd2
  } state_e;

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  state_e      state_q, state_d;
  logic        load_use;
  logic        hz_idle;
  logic        code3;
  logic [2:0]  hold_flag;
  logic        bubble;
  logic        jump_flag;
  logic [31:0] jump_addr;

  assign load_use = bus.ld_ex_i
                  & (bus.ex_rd_i != 5'd0)
                  & ((bus.ex_rd_i == bus.id_rs1_i)
                   | (bus.ex_rd_i == bus.id_rs2_i));

  // LDSTALL/FLUSH mask hazard detection
  assign hz_idle = load_use & (state_q == IDLE);

  assign code3 = bus.jump_flag_i
               | (state_q == FLUSH)
               | bus.hold_flag_clint_i
               | bus.hold_flag_ex_i;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE: begin
        if (bus.jump_flag_i) state_d = FLUSH;
        else if (bubble)     state_d = LDSTALL;
      end
      FLUSH:   if (bus.jump_flag_i) state_d = FLUSH;
      LDSTALL: if (bus.jump_flag_i) state_d = FLUSH;
      default: state_d = IDLE;
    endcase
  end

  // everything forced quiet while in reset
  always_comb begin
    hold_flag = HOLD_NONE;
    bubble    = 1'b0;
    jump_flag = 1'b0;
    jump_addr = 32'd0;
    if (rst) begin
      jump_flag = bus.jump_flag_i;
      jump_addr = bus.jump_flag_i ? bus.jump_addr_i : 32'd0;
      if (code3)
        hold_flag = HOLD_ID;
      else if (bus.hold_flag_rib_i | hz_idle)
        hold_flag = HOLD_PC;
      bubble = hz_idle & ~code3;
    end
  end

  assign bus.hold_flag_o = hold_flag;
  assign bus.bubble_o    = bubble;
  assign bus.jump_flag_o = jump_flag;
  assign bus.jump_addr_o = jump_addr;
  assign bus.state_o     = rst ? state_q : 2'd0;

`ifdef PIPE_CTRL_STAT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if ((hold_flag != HOLD_NONE) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.jump_flag_i && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, corner
// sequences and random stimulus against a behavioural model.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_STAT_EN
  logic [31:0] stall_cnt, flush_cnt;
  pipe_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );
`else
  pipe_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic j, input logic [31:0] a,
                       input logic ex, input logic cl,
                       input logic rb, input logic ld,
                       input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2);
    bus.jump_flag_i       = j;
    bus.jump_addr_i       = a;
    bus.hold_flag_ex_i    = ex;
    bus.hold_flag_clint_i = cl;
    bus.hold_flag_rib_i   = rb;
    bus.ld_ex_i           = ld;
    bus.ex_rd_i           = rd;
    bus.id_rs1_i          = r1;
    bus.id_rs2_i          = r2;
  endtask

  task automatic idle_in();
    drive(0, 32'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic chk_out(input string nm, input logic [2:0] h,
                         input logic b, input logic jf,
                         input logic [31:0] ja, input logic [1:0] s);
    chk({nm, ".hold"},  32'(bus.hold_flag_o), 32'(h));
    chk({nm, ".bub"},   32'(bus.bubble_o),    32'(b));
    chk({nm, ".jflag"}, 32'(bus.jump_flag_o), 32'(jf));
    chk({nm, ".jaddr"}, bus.jump_addr_o,      ja);
    chk({nm, ".state"}, 32'(bus.state_o),     32'(s));
  endtask

  typedef struct packed {
    logic        j;
    logic [31:0] a;
    logic        ex, cl, rb, ld;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  hold;
    logic        bub;
    logic        jf;
    logic [31:0] ja;
    logic [1:0]  st;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  // behavioural model state
  bit          m_flush, m_mask;
  logic [31:0] m_stall, m_fcnt;

  initial begin
    // each vector: inputs this cycle, outputs seen this cycle
    vec[0]  = '{0,32'h0,  0,0,0,0, 5'd0,5'd0,5'd0, 3'd0,0,0,32'h0,  2'd0};
    vec[1]  = '{1,32'h100,0,0,0,0, 5'd0,5'd0,5'd0, 3'd3,0,1,32'h100,2'd0};
    vec[2]  = '{0,32'h0,  0,0,0,0, 5'd0,5'd0,5'd0, 3'd3,0,0,32'h0,  2'd1};
    vec[3]  = '{0,32'h0,  0,0,0,0, 5'd0,5'd0,5'd0, 3'd0,0,0,32'h0,  2'd0};
    vec[4]  = '{0,32'h0,  0,0,0,1, 5'd5,5'd0,5'd5, 3'd1,1,0,32'h0,  2'd0};
    vec[5]  = '{0,32'h0,  0,0,0,0, 5'd0,5'd0,5'd0, 3'd0,0,0,32'h0,  2'd2};
    vec[6]  = '{0,32'h0,  0,0,0,1, 5'd0,5'd0,5'd0, 3'd0,0,0,32'h0,  2'd0};
    vec[7]  = '{1,32'h200,0,0,0,1, 5'd5,5'd5,5'd0, 3'd3,0,1,32'h200,2'd0};
    vec[8]  = '{1,32'h300,0,0,0,0, 5'd0,5'd0,5'd0, 3'd3,0,1,32'h300,2'd1};
    vec[9]  = '{0,32'h0,  0,0,0,1, 5'd7,5'd7,5'd0, 3'd3,0,0,32'h0,  2'd1};
    vec[10] = '{0,32'h0,  0,0,0,1, 5'd7,5'd7,5'd0, 3'd1,1,0,32'h0,  2'd0};
    vec[11] = '{0,32'h0,  0,0,0,1, 5'd7,5'd7,5'd0, 3'd0,0,0,32'h0,  2'd2};
    vec[12] = '{0,32'h0,  0,1,0,1, 5'd7,5'd0,5'd7, 3'd3,0,0,32'h0,  2'd0};
    vec[13] = '{0,32'h0,  0,0,0,1, 5'd7,5'd0,5'd7, 3'd1,1,0,32'h0,  2'd0};
    vec[14] = '{0,32'h0,  0,0,1,0, 5'd0,5'd0,5'd0, 3'd1,0,0,32'h0,  2'd2};
    vec[15] = '{0,32'hdead,0,0,0,0,5'd0,5'd0,5'd0, 3'd0,0,0,32'h0,  2'd0};

    // reset with noisy inputs: outputs must be quiet
    rst = 1'b0;
    drive(1, 32'h1234, 1, 1, 1, 1, 5'd3, 5'd3, 5'd3);
    repeat (2) begin
      @(negedge clk); #2;
      chk_out("rst_quiet", 3'd0, 0, 0, 32'h0, 2'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    idle_in();

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].j, vec[i].a, vec[i].ex, vec[i].cl,
            vec[i].rb, vec[i].ld, vec[i].rd, vec[i].r1,
            vec[i].r2);
      #2;
      chk_out($sformatf("vec%0d", i), vec[i].hold, vec[i].bub,
              vec[i].jf, vec[i].ja, vec[i].st);
      @(negedge clk);
    end

    // rib+ex level holds, then ex drops
    drive(0, 32'd0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("ribex.hold", 32'(bus.hold_flag_o), 32'd3);
      @(negedge clk);
    end
    bus.hold_flag_ex_i = 1'b0;
    #2;
    chk("rib_only.hold", 32'(bus.hold_flag_o), 32'd1);
    @(negedge clk);

    // reset landing in FLUSH while jump is still requested
    drive(1, 32'h40, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk_out("rst_flush", 3'd0, 0, 0, 32'h0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_in();
    #2;
    chk_out("post_rst", 3'd0, 0, 0, 32'h0, 2'd0);
`ifdef PIPE_CTRL_STAT_EN
    chk("post_rst.stall_cnt", stall_cnt, 32'd0);
    chk("post_rst.flush_cnt", flush_cnt, 32'd0);
`endif

    // random phase, model starts from reset
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_flush = 0; m_mask = 0;
    m_stall = 0; m_fcnt = 0;
    for (int c = 0; c < 600; c++) begin
      logic        j, ex, cl, rb, ld, haz, c3, bub, r;
      logic [4:0]  rd, r1, r2;
      logic [31:0] a;
      logic [2:0]  h;
      logic [1:0]  s;
      r  = ($urandom_range(0, 19) != 0);
      j  = ($urandom_range(0, 5) == 0);
      ex = ($urandom_range(0, 7) == 0);
      cl = ($urandom_range(0, 7) == 0);
      rb = ($urandom_range(0, 5) == 0);
      ld = $urandom_range(0, 1) == 1;
      rd = 5'($urandom_range(0, 3));
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      a  = $urandom;
      rst = r;
      drive(j, a, ex, cl, rb, ld, rd, r1, r2);
      if (r) begin
        c3  = j | m_flush | cl | ex;
        haz = !m_flush && !m_mask && ld && rd != 0
              && (rd == r1 || rd == r2);
        h   = c3 ? 3'd3 : ((rb || haz) ? 3'd1 : 3'd0);
        bub = haz && !c3;
        s   = m_flush ? 2'd1 : (m_mask ? 2'd2 : 2'd0);
      end else begin
        h = 0; bub = 0; s = 0; c3 = 0;
      end
      #2;
      chk_out($sformatf("rnd%0d", c), h, bub, r & j,
              (r & j) ? a : 32'h0, s);
`ifdef PIPE_CTRL_STAT_EN
      chk("rnd.stall_cnt", stall_cnt, m_stall);
      chk("rnd.flush_cnt", flush_cnt, m_fcnt);
`endif
      if (r) begin
        m_flush = j;
        m_mask  = bub;
        if (h != 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (j && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
      end else begin
        m_flush = 0; m_mask = 0;
        m_stall = 0; m_fcnt = 0;
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-low reset.
REQ-003 jump_flag_i  in  1  EX-stage redirect request (branch taken / jal / jalr).
REQ-004 jump_addr_i  in  32  redirect target from EX.
REQ-005 hold_flag_ex_i  in  1  EX multi-cycle busy (divider).
REQ-006 hold_flag_clint_i  in  1  interrupt controller pipeline-hold request.
REQ-007 hold_flag_rib_i  in  1  bus-arbiter hold request (master lost bus).
REQ-008 ld_ex_i  in  1  instruction currently in EX is a load.
REQ-009 ex_rd_i, id_rs1_i, id_rs2_i  in  5 each  EX destination / ID source register indices.
REQ-010 hold_flag_o  out  3  hold code to pc/if_id/id_ex: 0 none, 1 Hold_Pc, 2 Hold_If, 3 Hold_Id.
REQ-011 bubble_o  out  1  id_ex loads NOP while if_id holds its contents.
REQ-012 jump_flag_o, jump_addr_o  out  1, 32  redirect to PC register.
REQ-013 state_o  out  2  current FSM state (debug).

Function
REQ-014 States: IDLE=0, FLUSH=1, LDSTALL=2; code 3 unreachable, decodes to IDLE next cycle.
REQ-015 jump_flag_o/jump_addr_o combinationally equal jump_flag_i/jump_addr_i in the same cycle; jump_addr_o SHALL be 0 when jump_flag_i=0.
REQ-016 Load-use hazard = ld_ex_i & (ex_rd_i!=0) & (ex_rd_i==id_rs1_i | ex_rd_i==id_rs2_i); x0 never hazards.
REQ-017 hold_flag_o = max of per-source codes, same cycle: jump_flag_i->3, state FLUSH->3, hold_flag_clint_i->3, hold_flag_ex_i->3, hold_flag_rib_i->1, load-use in IDLE->1.
REQ-018 bubble_o = 1 only when load-use is detected in IDLE and hold_flag_o==1 (no code-3 source active); otherwise 0.
REQ-019 IDLE->FLUSH on jump_flag_i; FLUSH lasts exactly one cycle so two consecutive cycles emit code 3 (jump cycle + FLUSH).
REQ-020 FLUSH->FLUSH if jump_flag_i reasserts in FLUSH (window restarts); else FLUSH->IDLE.
REQ-021 IDLE->LDSTALL when bubble_o=1; LDSTALL masks hazard detection for one cycle, then ->IDLE (or ->FLUSH on jump_flag_i).
REQ-022 Simultaneous jump and load-use: jump wins, bubble_o=0, next state FLUSH.
REQ-023 Load-use concurrent with any code-3 source: bubble_o=0, state stays IDLE; hazard re-evaluated next cycle.
REQ-024 hold_flag_ex_i/clint/rib are level requests; output tracks them every cycle with zero latency, no latching.

Reset
REQ-025 rst=0 at a clock edge: state->IDLE regardless of current state, including mid-FLUSH/LDSTALL.
REQ-026 While rst=0: hold_flag_o=0, bubble_o=0, jump_flag_o=0, jump_addr_o=0, state_o=0, all inputs ignored.
REQ-027 First cycle after rst=1 behaves as IDLE with no pending flush.

Configuration
REQ-028 Macro PIPE_CTRL_STAT_EN defined: adds outputs stall_cnt_o[31:0] (cycles with hold_flag_o!=0) and flush_cnt_o[31:0] (cycles with jump_flag_i=1); both reset to 0, saturate at 0xFFFFFFFF.
REQ-029 Macro undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-030 jump_flag_i=1, jump_addr_i=0x0000_0100 for 1 cycle -> jump_flag_o=1, addr 0x100 that cycle; hold_flag_o=3 for 2 cycles; state IDLE->FLUSH->IDLE.
REQ-031 ld_ex_i=1, ex_rd_i=5, id_rs2_i=5 -> hold_flag_o=1, bubble_o=1 one cycle; next cycle LDSTALL, hold_flag_o=0; ex_rd_i=0 variant -> no stall.
REQ-032 Jump and load-use same cycle -> hold_flag_o=3, bubble_o=0, next state FLUSH.
REQ-033 hold_flag_rib_i=1 with hold_flag_ex_i=1 for 4 cycles -> hold_flag_o=3 each cycle; drop ex -> hold_flag_o=1 next cycle.
REQ-034 rst=0 during FLUSH -> state_o=0, hold_flag_o=0 after that edge; with PIPE_CTRL_STAT_EN counters read 0.
